ram_march_bist: RTL and testbench

- Initiator-side test engine that drives the port of the single-port Synchronous_RAM (we/addr/data_in in, data_out out) and checks the read data.
- Runs a four-phase pattern test on start:
  - write pattern
  - read and compare
  - write inverted pattern
  - read and compare inverted
- Reports pass/fail, the first failing address and data, and an error count.
- Sits between the system controller and the RAM instance for power-on and production self-test.

---
 rtl/ram_march_bist.sv | 159 +++++++++++++++
 tb/tb_ram_march_bist.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// Four-phase pattern self-test engine for a single-port synchronous RAM.
// Optional macro BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module ram_march_bist #(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] SEED         = DATA_W'(32'hA5A5_0000),
  parameter int unsigned       READ_LATENCY = 1,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  err_count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN0, DRAIN1, FIN} state_t;

  state_t            state;
  logic [LAT_W-1:0]  drain_cnt;
  logic              pipe_v    [READ_LATENCY];
  logic [ADDR_W-1:0] pipe_addr [READ_LATENCY];
  logic [DATA_W-1:0] pipe_exp  [READ_LATENCY];
  logic              mismatch_c;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return SEED + DATA_W'(a);
  endfunction

  // Oldest pipeline entry lines up with the RAM word it requested
  always_comb begin
    mismatch_c = 1'b0;
    if (pipe_v[READ_LATENCY-1] && (ram_rdata != pipe_exp[READ_LATENCY-1]))
      mismatch_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_exp[i]  <= '0;
      end
    end else begin
      done <= 1'b0;

      for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
      pipe_v[0]    <= (state == R0) || (state == R1);
      pipe_addr[0] <= ram_addr;
      pipe_exp[0]  <= (state == R1) ? ~pattern(ram_addr) : pattern(ram_addr);

      if (mismatch_c) begin
        if (err_count != '1)
          err_count <= err_count + CNT_W'(1);
        if (err_count == '0) begin
          fail_addr <= pipe_addr[READ_LATENCY-1];
          fail_data <= ram_rdata;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= W0;
            busy      <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= pattern('0);
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
          end
        end
        W0, W1: begin
          if (&ram_addr) begin
            state    <= (state == W0) ? R0 : R1;
            ram_we   <= 1'b0;
            ram_addr <= '0;
          end else begin
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= (state == W0) ? pattern(ram_addr + ADDR_W'(1))
                                       : ~pattern(ram_addr + ADDR_W'(1));
          end
        end
        R0, R1: begin
          if (&ram_addr) begin
            state     <= (state == R0) ? DRAIN0 : DRAIN1;
            ram_addr  <= '0;
            drain_cnt <= '0;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
          end
        end
        DRAIN0: begin
          if (drain_cnt == LAT_W'(READ_LATENCY - 1)) begin
            state     <= W1;
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= ~pattern('0);
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end
        DRAIN1: begin
          if (drain_cnt == LAT_W'(READ_LATENCY - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch_c;
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

`ifdef BIST_STOP_ON_FAIL_EN
      // Abort: discard younger reads and finish on this edge
      if (mismatch_c && busy) begin
        state  <= FIN;
        busy   <= 1'b0;
        done   <= 1'b1;
        pass   <= 1'b0;
        ram_we <= 1'b0;
        for (int i = 0; i < int'(READ_LATENCY); i++)
          pipe_v[i] <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist: two instances (CNT_W 16 and 4), each with
// a registered-output RAM model supporting a stuck bit0 and a one-word corruption.
module tb_ram_march_bist;

  localparam int          DEPTH   = 256;
  localparam int          RUN_LEN = 4 * DEPTH + 2;
  localparam logic [31:0] SEED    = 32'hA5A5_0000;
`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct packed {
    logic        pass;
    logic        pass4;
    logic [15:0] err;
    logic [3:0]  err4;
    logic [7:0]  faddr;
    logic [7:0]  faddr4;
    logic [31:0] fdata;
    logic [31:0] fdata4;
  } res_t;

  logic clk = 1'b0;
  logic rst, start, stuck0, corrupt_req;

  logic        busy, done, pass, ram_we;
  logic [7:0]  fail_addr, ram_addr;
  logic [31:0] fail_data, ram_wdata, ram_rdata;
  logic [15:0] err_count;

  logic        busy_b, done_b, pass_b, ram_we_b;
  logic [7:0]  fail_addr_b, ram_addr_b;
  logic [31:0] fail_data_b, ram_wdata_b, ram_rdata_b;
  logic [3:0]  err_count_b;

  ram_march_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_march_bist #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fail_addr_b), .fail_data(fail_data_b), .err_count(err_count_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
  );

  always #5 clk = ~clk;

  // RAM models
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] rq_a, rq_b;

  always_ff @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_wdata;
    else if (corrupt_req) mem_a[20] <= '0;
    rq_a <= mem_a[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    else if (corrupt_req) mem_b[20] <= '0;
    rq_b <= mem_b[ram_addr_b];
  end

  assign ram_rdata   = rq_a & ~{31'b0, stuck0};
  assign ram_rdata_b = rq_b & ~{31'b0, stuck0};

  // Run monitor on the main instance
  int          cyc = 0, done_cnt = 0, done_cyc = 0, busy_len = 0;
  int          wr_idx = 0, wr_bad = 0, rd20_cyc = -1;
  logic [31:0] w0_10 = '0, w1_10 = '0, exp_w;
  logic        busy_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !busy_q) begin
      busy_len = 0;
      wr_idx   = 0;
      wr_bad   = 0;
      rd20_cyc = -1;
    end
    if (busy) busy_len++;
    if (ram_we) begin
      exp_w = (wr_idx < DEPTH) ? SEED + 32'(wr_idx) : ~(SEED + 32'(wr_idx - DEPTH));
      if (ram_addr !== 8'(wr_idx) || ram_wdata !== exp_w) wr_bad++;
      if (wr_idx == 10) w0_10 = ram_wdata;
      if (wr_idx == DEPTH + 10) w1_10 = ram_wdata;
      wr_idx++;
    end
    if (busy && !ram_we && ram_addr == 8'd20 && wr_idx == DEPTH && rd20_cyc < 0)
      rd20_cyc = cyc;
    busy_q = busy;
  end

  int   checks = 0, failures = 0;
  res_t sb_q [$];
  res_t got, exp_r;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stuck0 = 1'b0; corrupt_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, ram_we, busy_b, done_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, pass, ram_we, busy_b, done_b});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== 40'h0) begin
      failures++;
      $display("FAIL reset_ram_port got addr=%h wdata=%h exp 0", ram_addr, ram_wdata);
    end
    checks++;
    if ({err_count, fail_addr, fail_data} !== 56'h0) begin
      failures++;
      $display("FAIL reset_result got err=%h faddr=%h fdata=%h exp 0", err_count, fail_addr, fail_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_run();
    bit ok;
    int d0 = done_cnt;
    sb_q.push_back('{pass: 1'b1, pass4: 1'b1, default: '0});
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL good_timeout got=no_done exp=done"); end
    checks++;
    if ({busy, done_b} !== 2'b01) begin
      failures++;
      $display("FAIL good_fin_flags got busy=%b done_b=%b exp busy=0 done_b=1", busy, done_b);
    end
    @(negedge clk);
    exp_r = sb_q.pop_front();
    got = {pass, pass_b, err_count, err_count_b, fail_addr, fail_addr_b, fail_data, fail_data_b};
    checks++;
    if (got !== exp_r) begin failures++; $display("FAIL good_result got=%h exp=%h", got, exp_r); end
    checks++;
    if (busy_len !== RUN_LEN) begin failures++; $display("FAIL good_busy_len got=%0d exp=%0d", busy_len, RUN_LEN); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL good_done_count got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (w0_10 !== 32'hA5A5_000A) begin failures++; $display("FAIL w0_addr10 got=%h exp=a5a5000a", w0_10); end
    checks++;
    if (w1_10 !== 32'h5A5A_FFF5) begin failures++; $display("FAIL w1_addr10 got=%h exp=5a5afff5", w1_10); end
    checks++;
    if (wr_bad !== 0 || wr_idx !== 2 * DEPTH) begin
      failures++;
      $display("FAIL write_stream got bad=%0d writes=%0d exp bad=0 writes=%0d", wr_bad, wr_idx, 2 * DEPTH);
    end
  endtask

  task automatic test_stuck_bit();
    bit ok;
    stuck0 = 1'b1;
    sb_q.push_back('{pass: 1'b0, pass4: 1'b0,
                     err: STOP ? 16'd1 : 16'd256, err4: STOP ? 4'd1 : 4'd15,
                     faddr: 8'd1, faddr4: 8'd1,
                     fdata: 32'hA5A5_0000, fdata4: 32'hA5A5_0000});
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stuck_timeout got=no_done exp=done"); end
    @(negedge clk);
    exp_r = sb_q.pop_front();
    got = {pass, pass_b, err_count, err_count_b, fail_addr, fail_addr_b, fail_data, fail_data_b};
    checks++;
    if (got !== exp_r) begin failures++; $display("FAIL stuck_result got=%h exp=%h", got, exp_r); end
    checks++;
    if (busy_len !== (STOP ? 259 : RUN_LEN)) begin
      failures++;
      $display("FAIL stuck_busy_len got=%0d exp=%0d", busy_len, STOP ? 259 : RUN_LEN);
    end
    stuck0 = 1'b0;
  endtask

  task automatic test_restart_ignored();
    bit ok;
    int d0 = done_cnt;
    sb_q.push_back('{pass: 1'b1, pass4: 1'b1, default: '0});
    pulse_start();
    repeat (98) @(negedge clk);
    pulse_start();
    repeat (598) @(negedge clk);
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL restart_timeout got=no_done exp=done"); end
    @(negedge clk);
    exp_r = sb_q.pop_front();
    got = {pass, pass_b, err_count, err_count_b, fail_addr, fail_addr_b, fail_data, fail_data_b};
    checks++;
    if (got !== exp_r) begin failures++; $display("FAIL restart_result got=%h exp=%h", got, exp_r); end
    checks++;
    if (busy_len !== RUN_LEN) begin failures++; $display("FAIL restart_busy_len got=%0d exp=%0d", busy_len, RUN_LEN); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_single_run got dones=%0d busy=%b exp dones=1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int d0 = done_cnt;
    pulse_start();
    repeat (599) @(negedge clk);
    checks++;
    if ({busy, ram_we} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b we=%b exp 1 1", busy, ram_we);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, ram_we, ram_we_b} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_async got busy=%b we=%b we_b=%b exp 0 0 0", busy, ram_we, ram_we_b);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || err_count !== 16'd0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet got dones=%0d err=%0d pass=%b exp dones=0 err=0 pass=0",
               done_cnt - d0, err_count, pass);
    end
    sb_q.push_back('{pass: 1'b1, pass4: 1'b1, default: '0});
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_rerun_timeout got=no_done exp=done"); end
    @(negedge clk);
    exp_r = sb_q.pop_front();
    got = {pass, pass_b, err_count, err_count_b, fail_addr, fail_addr_b, fail_data, fail_data_b};
    checks++;
    if (got !== exp_r) begin failures++; $display("FAIL midrst_rerun_result got=%h exp=%h", got, exp_r); end
    checks++;
    if (busy_len !== RUN_LEN) begin failures++; $display("FAIL midrst_rerun_len got=%0d exp=%0d", busy_len, RUN_LEN); end
  endtask

  task automatic test_corrupt_word();
    bit ok = 1'b0;
    sb_q.push_back('{pass: 1'b0, pass4: 1'b0, err: 16'd1, err4: 4'd1,
                     faddr: 8'd20, faddr4: 8'd20, fdata: 32'h0, fdata4: 32'h0});
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy && !ram_we) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL corrupt_r0_timeout got=no_read_phase exp=read_phase"); end
    corrupt_req = 1'b1;
    @(negedge clk);
    corrupt_req = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL corrupt_timeout got=no_done exp=done"); end
    @(negedge clk);
    exp_r = sb_q.pop_front();
    got = {pass, pass_b, err_count, err_count_b, fail_addr, fail_addr_b, fail_data, fail_data_b};
    checks++;
    if (got !== exp_r) begin failures++; $display("FAIL corrupt_result got=%h exp=%h", got, exp_r); end
    checks++;
    if (done_cyc - rd20_cyc !== (STOP ? 2 : 750)) begin
      failures++;
      $display("FAIL corrupt_done_delay got=%0d exp=%0d", done_cyc - rd20_cyc, STOP ? 2 : 750);
    end
    checks++;
    if (busy_len !== (STOP ? 278 : RUN_LEN) || wr_idx !== (STOP ? DEPTH : 2 * DEPTH)) begin
      failures++;
      $display("FAIL corrupt_extent got len=%0d writes=%0d exp len=%0d writes=%0d",
               busy_len, wr_idx, STOP ? 278 : RUN_LEN, STOP ? DEPTH : 2 * DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_stuck_bit();
    test_restart_ignored();
    test_reset_mid_run();
    test_corrupt_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
